// File: rtl/credit_sched_pkg.sv
// credit_sched_pkg
//   Shared widths and the round-robin search helper for credit_rr_scheduler.
//   id_w(n)      : width of a requester index for n requesters.
//   cnt_w(n)     : width of a credit counter that must hold 0..n.
//   next_rr(...) : {found, index} of the first eligible requester after 'last'.
package credit_sched_pkg;

   // Upper bound on requester count supported by the search helper.
   localparam int unsigned MAX_REQ  = 64;
   localparam int unsigned MAX_ID_W = 6;

   function automatic int unsigned id_w(input int unsigned n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned n_credits);
      return $clog2(n_credits + 1);
   endfunction

   typedef struct packed {
      logic                found;
      logic [MAX_ID_W-1:0] index;
   } rr_pick_t;

   // Scans last+1, last+2, ... wrapping at n; the first set bit wins.
   function automatic rr_pick_t next_rr(input logic [MAX_REQ-1:0] eligible,
                                        input int unsigned         last,
                                        input int unsigned         n);
      rr_pick_t    pick;
      int unsigned idx;
      pick = '0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         if (k <= n && !pick.found) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if (eligible[idx]) begin
               pick.found = 1'b1;
               pick.index = MAX_ID_W'(idx);
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational rotating-priority picker. Priority starts just after 'last'.
//   req        : request vector.
//   last       : index granted most recently.
//   gnt_onehot : one-hot grant (all zero when nothing requests).
//   gnt_idx    : binary index of the grant.
//   gnt_any    : a grant was made.
module rr_arbiter
   import credit_sched_pkg::*;
#(
   parameter  int unsigned N    = 4,
   localparam int unsigned ID_W = id_w(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic [N-1:0]    gnt_onehot,
   output logic [ID_W-1:0] gnt_idx,
   output logic            gnt_any
);

   rr_pick_t pick;

   always_comb begin
      pick       = next_rr(MAX_REQ'(req), 32'(last), N);
      gnt_any    = pick.found;
      gnt_idx    = ID_W'(pick.index);
      gnt_onehot = '0;
      if (pick.found) gnt_onehot[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/credit_rr_scheduler.sv
// credit_rr_scheduler
//   Grants at most one of N_REQ show-ahead FIFOs per cycle, round-robin among
//   requesters that are enabled, non-empty and hold credit. The granted FIFO is
//   popped combinationally and its head is forwarded one cycle later with its ID.
//   clock, reset      : clock and synchronous active-high reset.
//   i_chan_enable     : per-requester arbitration enable.
//   i_fifo_empty      : per-FIFO empty flags.
//   i_fifo_data       : FIFO heads, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
//   o_fifo_rd         : one-hot pop in the grant cycle.
//   i_credit_return   : one credit returned per set bit.
//   o_valid/o_data/o_id : registered forwarded word and its source.
//   o_credit_err      : sticky, a credit came back into a full pool.
module credit_rr_scheduler
   import credit_sched_pkg::*;
#(
   parameter  int unsigned N_REQ      = 4,
   parameter  int unsigned N_CREDITS  = 10,
   parameter  int unsigned DATA_WIDTH = 32,
   localparam int unsigned ID_W       = id_w(N_REQ),
   localparam int unsigned CNT_W      = cnt_w(N_CREDITS)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            i_chan_enable,
   input  logic [N_REQ-1:0]            i_fifo_empty,
   input  logic [N_REQ*DATA_WIDTH-1:0] i_fifo_data,
   output logic [N_REQ-1:0]            o_fifo_rd,
   input  logic [N_REQ-1:0]            i_credit_return,
   output logic                        o_valid,
   output logic [DATA_WIDTH-1:0]       o_data,
   output logic [ID_W-1:0]             o_id,
   output logic [N_REQ-1:0]            o_credit_err
);

   logic [N_REQ-1:0]      eligible;
   logic [N_REQ-1:0]      gnt_onehot;
   logic [ID_W-1:0]       gnt_idx;
   logic                  gnt_any;
   logic [ID_W-1:0]       last_grant;
   logic [DATA_WIDTH-1:0] head;

   rr_arbiter #(
      .N (N_REQ)
   ) u_arbiter (
      .req        (eligible),
      .last       (last_grant),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .gnt_any    (gnt_any)
   );

   // Pop is suppressed during reset so no FIFO loses a word that is never forwarded.
   assign o_fifo_rd = reset ? '0 : gnt_onehot;

   for (genvar i = 0; i < N_REQ; i++) begin : g_credit
      logic [CNT_W-1:0] credit;
      logic             err;
      logic             dec;
      logic             inc;

      assign dec             = gnt_onehot[i];
      assign inc             = i_credit_return[i];
      assign eligible[i]     = i_chan_enable[i] & ~i_fifo_empty[i] & (credit != '0);
      assign o_credit_err[i] = err;

      always_ff @(posedge clock) begin
         if (reset) begin
            credit <= CNT_W'(N_CREDITS);
            err    <= 1'b0;
         end else begin
            case ({dec, inc})
               2'b10: credit <= credit - 1'b1;
               2'b01: begin
                  // Overflowing return is absorbed and flagged.
                  if (credit == CNT_W'(N_CREDITS)) err <= 1'b1;
                  else                             credit <= credit + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      head = i_fifo_data[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
   end

   // o_data/o_id hold their last value on idle cycles; only o_valid qualifies them.
   always_ff @(posedge clock) begin
      if (reset) begin
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_id       <= '0;
         last_grant <= ID_W'(N_REQ - 1);
      end else begin
         o_valid <= gnt_any;
         if (gnt_any) begin
            o_data     <= head;
            o_id       <= gnt_idx;
            last_grant <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_credit_rr_scheduler.sv
module tb_credit_rr_scheduler;

   localparam int unsigned N   = 4;
   localparam int unsigned NC  = 10;
   localparam int unsigned DW  = 32;
   localparam int unsigned IDW = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    i_chan_enable = '0;
   logic [N-1:0]    i_fifo_empty = '1;
   logic [N*DW-1:0] i_fifo_data = '0;
   logic [N-1:0]    o_fifo_rd;
   logic [N-1:0]    i_credit_return = '0;
   logic            o_valid;
   logic [DW-1:0]   o_data;
   logic [IDW-1:0]  o_id;
   logic [N-1:0]    o_credit_err;

   credit_rr_scheduler #(
      .N_REQ      (N),
      .N_CREDITS  (NC),
      .DATA_WIDTH (DW)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .i_chan_enable   (i_chan_enable),
      .i_fifo_empty    (i_fifo_empty),
      .i_fifo_data     (i_fifo_data),
      .o_fifo_rd       (o_fifo_rd),
      .i_credit_return (i_credit_return),
      .o_valid         (o_valid),
      .o_data          (o_data),
      .o_id            (o_id),
      .o_credit_err    (o_credit_err)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int           m_credit[N];
   int           m_last;
   logic [N-1:0] m_err;
   logic         m_valid;
   logic [DW-1:0] m_data;
   int           m_id;
   int           grants[N];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_credit[i] = NC;
      m_last  = N - 1;
      m_err   = '0;
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 0;
   endtask

   task automatic clear_grants();
      for (int i = 0; i < N; i++) grants[i] = 0;
   endtask

   // One clock cycle: check registered outputs, drive inputs, check the pop,
   // then advance the model across the clock edge.
   task automatic step(input logic r, input logic [N-1:0] en, input logic [N-1:0] emp,
                       input logic [N-1:0] ret);
      bit            found;
      int            g;
      logic [N-1:0]  exp_rd;
      logic [DW-1:0] word;
      @(negedge clock);
      check_eq("valid", o_valid, m_valid);
      if (m_valid) begin
         check_eq("data", o_data, m_data);
         check_eq("id", o_id, m_id);
      end
      check_eq("credit_err", o_credit_err, m_err);
      reset           = r;
      i_chan_enable   = en;
      i_fifo_empty    = emp;
      i_credit_return = ret;
      for (int i = 0; i < N; i++) i_fifo_data[i*DW +: DW] = $urandom();
      #1;
      found = 0;
      g     = 0;
      if (!r) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!found && en[c] && !emp[c] && m_credit[c] > 0) begin
               found = 1;
               g     = c;
            end
         end
      end
      exp_rd = '0;
      if (found) exp_rd[g] = 1'b1;
      word = i_fifo_data[g*DW +: DW];
      check_eq("fifo_rd", o_fifo_rd, exp_rd);
      for (int i = 0; i < N; i++) if (o_fifo_rd[i]) grants[i]++;
      @(posedge clock);
      if (r) begin
         model_reset();
      end else begin
         for (int i = 0; i < N; i++) begin
            bit dec, inc;
            dec = found && (g == i);
            inc = ret[i];
            if (inc && !dec) begin
               if (m_credit[i] == NC) m_err[i] = 1'b1;
               else                   m_credit[i]++;
            end else if (dec && !inc) begin
               m_credit[i]--;
            end
         end
         m_valid = found;
         if (found) begin
            m_data = word;
            m_id   = g;
            m_last = g;
         end
      end
   endtask

   initial begin
      logic [N-1:0] en, emp, ret;
      model_reset();
      clear_grants();

      // Reset values
      step(1'b1, '0, '1, '0);
      step(1'b1, '1, '0, '0);
      #2;
      check_eq("rst_valid", o_valid, 0);
      check_eq("rst_data", o_data, 0);
      check_eq("rst_id", o_id, 0);
      check_eq("rst_err", o_credit_err, 0);

      // All eligible, no returns: 0,1,2,3,... until each pool of 10 is spent
      clear_grants();
      for (int c = 0; c < 45; c++) step(1'b0, '1, '0, '0);
      for (int i = 0; i < N; i++) check_eq($sformatf("drain_grants%0d", i), grants[i], NC);

      // Only requester 2 non-empty, returning every cycle
      step(1'b1, '1, '0, '0);
      clear_grants();
      for (int c = 0; c < 20; c++) step(1'b0, '1, 4'b1011, 4'b0100);
      check_eq("req2_grants", grants[2], 20);

      // Requester 1 drained, one return, then grant on the following cycle
      step(1'b1, '1, '0, '0);
      for (int c = 0; c < 12; c++) step(1'b0, '1, 4'b1101, '0);
      step(1'b0, '1, 4'b1101, 4'b0010);
      clear_grants();
      step(1'b0, '1, 4'b1101, '0);
      check_eq("ret_then_grant", grants[1], 1);

      // Simultaneous grant and return on requester 0
      step(1'b1, '1, '0, '0);
      for (int c = 0; c < 20; c++) step(1'b0, '1, 4'b1110, 4'b0001);

      // Overflowing return on requester 3 sets a sticky error
      step(1'b1, '1, '0, '0);
      step(1'b0, '1, '1, 4'b1000);
      for (int c = 0; c < 5; c++) step(1'b0, '1, '1, '0);
      step(1'b1, '1, '0, '0);
      step(1'b0, '1, '1, '0);

      // Reset right after a grant
      step(1'b1, '1, '0, '0);
      step(1'b0, '1, '0, '0);
      step(1'b0, '1, '0, '0);
      step(1'b1, '1, '0, '0);
      step(1'b0, '1, '0, '0);

      // Randomised traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            en[i]  = ($urandom_range(0, 9) != 0);
            emp[i] = ($urandom_range(0, 9) < 3);
            if (m_credit[i] < NC) ret[i] = ($urandom_range(0, 9) < 4);
            else                  ret[i] = ($urandom_range(0, 99) == 0);
         end
         step($urandom_range(0, 199) == 0, en, emp, ret);
      end
      step(1'b0, '0, '1, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/credit_rr_scheduler.md
# credit_rr_scheduler

Schedules N_REQ latency-insensitive input FIFOs onto one shared downstream link, enforcing a separate credit pool per requester. It grants at most one FIFO per cycle, round-robin among requesters that have both data and credit, pops that FIFO, and forwards its word with the requester ID. The block sits between the per-channel show-ahead FIFOs and a shared relay/consumer that returns one credit per consumed word.

## Interface
Parameters
- N_REQ, 4: number of requesters; at least 2.
- N_CREDITS, 10: initial and maximum credits per requester; at least 1.
- DATA_WIDTH, 32: word width.

Ports
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- i_chan_enable  in  N_REQ  per-requester enable; a 0 excludes that requester from arbitration.
- i_fifo_empty  in  N_REQ  per-FIFO empty flag; FIFOs are show-ahead.
- i_fifo_data  in  N_REQ*DATA_WIDTH  FIFO heads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- o_fifo_rd  out  N_REQ  one-hot pop, combinational in the grant cycle.
- i_credit_return  in  N_REQ  +1 credit to requester i this cycle.
- o_valid  out  1  registered output word valid.
- o_data  out  DATA_WIDTH  registered forwarded word.
- o_id  out  $clog2(N_REQ)  registered source requester of o_data.
- o_credit_err  out  N_REQ  sticky flag: credit return with pool already full.

## Operation
- Credit counters: credit[i], width $clog2(N_CREDITS+1).
  - Reset value is N_CREDITS.
- Eligibility: eligible[i] = i_chan_enable[i] && !i_fifo_empty[i] && credit[i] != 0.
- Arbitration is round-robin. The search starts at last_grant+1 and wraps modulo N_REQ. The first eligible index wins.
- If no requester is eligible:
  - o_fifo_rd is all zero.
  - last_grant is unchanged.
  - o_valid goes 0 on the next cycle.
- On a grant to g:
  - o_fifo_rd[g] = 1 in the same cycle.
  - last_grant <= g.
  - o_data <= head of FIFO g, o_id <= g, o_valid <= 1.
- Credit update per requester i, with dec = grant to i and inc = i_credit_return[i]:
  - dec only: credit - 1.
  - inc only: credit + 1.
  - both: unchanged.
  - inc with credit == N_CREDITS and no dec: credit stays N_CREDITS and o_credit_err[i] is set.
- Credit never underflows, because eligibility requires credit != 0.
- o_credit_err clears only on reset.
- Reset:
  - credits = N_CREDITS.
  - last_grant = N_REQ-1, so requester 0 has first priority.
  - o_valid = 0, o_data = 0, o_id = 0, o_credit_err = 0.
  - o_fifo_rd is 0 while reset is asserted.
- Reset mid-operation: a word already registered is dropped. Downstream must reset in the same cycle.
- An i_chan_enable deassertion takes effect on the same-cycle grant decision. Credits are retained.

## Timing
- Grant and pop: combinational from registered state and current inputs. One grant at most per cycle.
- Pop to o_valid: 1 cycle.
- Throughput: 1 word per cycle sustained when eligible requesters exist.
- Credit effect: a return in cycle t can enable a grant in cycle t+1, not t.
- A grant in cycle t is reflected in credit at t+1.
- Fairness: with all requesters continuously eligible, each is granted exactly once every N_REQ cycles.
- There is no backpressure input. The downstream must accept every o_valid word; credits guarantee buffer space.

## Structure
- Package credit_sched_pkg:
  - ID_W = $clog2(N_REQ) and CNT_W = $clog2(N_CREDITS+1), as functions of the parameters.
  - Helper function next_rr(eligible, last) returning {found, index}.
- Sub-module rr_arbiter (parameter N): combinational rotating-priority picker.
  - Inputs: req[N], last[ID_W].
  - Outputs: gnt_onehot[N], gnt_idx, gnt_any.
- Per-requester credit counters and the output register stage stay in the top module, in a generate loop.

## Test plan
- After reset, all FIFOs non-empty, N_REQ=4, no returns:
  - grants go 0,1,2,3,0,1,…
  - o_id trails o_fifo_rd by 1 cycle.
  - each requester stalls after 10 grants; o_valid drops at cycle 41.
- Only requester 2 non-empty, with a return every cycle: o_fifo_rd=4'b0100 every cycle, and credit[2] stays at 10 after the first grant.
- credit[1]=0 with FIFO 1 non-empty, then a single return in cycle t: grant to 1 in cycle t+1, not t.
- Simultaneous grant and return on requester 0 for 20 cycles: credit[0] constant at 10, and o_credit_err stays 0.
- Return to requester 3 while credit[3]=10 with no grant: credit[3] stays 10, and o_credit_err[3]=1 until reset.
- Reset asserted the cycle after a grant: o_valid=0 next cycle, credits=10, next grant goes to requester 0.
